// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_pkg
// Description : Shared types, constants and helpers for the HI/LO multiply unit
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    // Default operand width; each of HI and LO is this wide.
    localparam int DEFAULT_WIDTH = 32;

    // Widest operand the magnitude helper can handle.
    localparam int MAX_WIDTH = 64;

    // Multiplier sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Conditional two's-complement magnitude. The caller sign-extends the
    // operand to MAX_WIDTH first, so the low WIDTH bits of the result are the
    // WIDTH-bit magnitude (the most negative value maps to 2^(WIDTH-1)).
    function automatic logic [MAX_WIDTH-1:0] abs_w(
        input logic [MAX_WIDTH-1:0] value,
        input logic                 take_abs
    );
        if (take_abs && value[MAX_WIDTH-1]) begin
            abs_w = ~value + 1'b1;
        end else begin
            abs_w = value;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_mult_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mult_unit_if
// Description : Request/response bundle between control unit and HI/LO unit
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_mult_unit_if #(
    parameter int WIDTH = hilo_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    // Control unit side: issues requests, observes status and HI/LO.
    modport master (
        output start, is_signed, op_a, op_b, mthi, mtlo, wdata,
        input  busy, done, hi_out, lo_out
    );

    // HI/LO unit side.
    modport slave (
        input  start, is_signed, op_a, op_b, mthi, mtlo, wdata,
        output busy, done, hi_out, lo_out
    );
endinterface
`default_nettype wire

// File: rtl/shift_add_core.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_core
// Description : Unsigned shift-add datapath, one multiplier bit per step
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   acc_out,
    output logic                 last
);

    localparam int              CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Load fresh operands, or perform one add-and-shift step (LSB first).
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand_in};
            mplier_d = mplier_in;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // Datapath registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc_out = acc_q;
    assign last    = (cnt_q == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/hilo_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mult_unit
// Description : Iterative signed/unsigned multiplier with architectural HI/LO
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    hilo_mult_unit_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_FINISH = FINISH;

    generate
        if (WIDTH > MAX_WIDTH || WIDTH < 1) begin : g_width_check
            $error("hilo_mult_unit: WIDTH out of supported range");
        end
    endgenerate

    logic [1:0]         state_q, state_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               core_load;
    logic               core_step;
    logic               core_last;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;

    // Operand magnitudes for the unsigned core; raw values for MULTU.
    always_comb begin
        a_mag = WIDTH'(abs_w(MAX_WIDTH'($signed(bus.op_a)), bus.is_signed));
        b_mag = WIDTH'(abs_w(MAX_WIDTH'($signed(bus.op_b)), bus.is_signed));
    end

    assign core_load = (state_q == S_IDLE) && bus.start;
    assign core_step = (state_q == S_RUN);

    shift_add_core #(
        .WIDTH     (WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load),
        .step      (core_step),
        .mcand_in  (a_mag),
        .mplier_in (b_mag),
        .acc_out   (acc),
        .last      (core_last)
    );

    // Sign fix-up of the unsigned accumulator.
    always_comb begin
        product = neg_q ? (~acc + 1'b1) : acc;
    end

    // Sequencing plus HI/LO write selection (direct moves only when idle).
    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mthi) begin
                    hi_d = bus.wdata;
                end
                if (bus.mtlo) begin
                    lo_d = bus.wdata;
                end
                if (bus.start) begin
                    state_d = S_RUN;
                    neg_d   = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                end
            end
            S_RUN: begin
                if (core_last) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                hi_d    = product[2*WIDTH-1:WIDTH];
                lo_d    = product[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and architectural registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_mult_unit
// Description : Self-checking bench for hilo_mult_unit (WIDTH = 32)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_mult_unit;

    localparam int W       = 32;
    localparam int LATENCY = W + 1;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    hilo_mult_unit_if #(.WIDTH(W)) bus ();

    hilo_mult_unit #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: full-width product from plain integer arithmetic.
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    // Full multiply transaction with latency, result and post-done checks.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
        logic [63:0] exp;
        int          cycles;
        exp           = ref_product(a, b, s);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.is_signed = s;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(cycles);
        check({tag, "_lat"}, 64'(cycles), 64'(LATENCY));
        check({tag, "_hi"}, 64'(bus.hi_out), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(bus.lo_out), 64'(exp[31:0]));
        tick();
        check({tag, "_done_off"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int          cycles;
        int          dones;
        logic [31:0] ra, rb;
        logic        rs;

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.mthi      = 1'b0;
        bus.mtlo      = 1'b0;
        bus.wdata     = '0;
        reset         = 1'b1;
        tick();
        tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi_out), 64'd0);
        check("rst_lo", 64'(bus.lo_out), 64'd0);
        reset = 1'b0;
        tick();

        // Unsigned extremes and signed corner cases.
        run_mul("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mul("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
        run_mul("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_mul("u_0x7f", 32'd0, 32'h7FFF_FFFF, 1'b0);
        run_mul("u_1xff", 32'd1, 32'hFFFF_FFFF, 1'b0);

        // Direct moves while idle, separately and together.
        bus.wdata = 32'h1234_5678;
        bus.mthi  = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        bus.wdata = 32'h9ABC_DEF0;
        bus.mtlo  = 1'b1;
        tick();
        bus.mtlo = 1'b0;
        check("mthi_idle", 64'(bus.hi_out), 64'h1234_5678);
        check("mtlo_idle", 64'(bus.lo_out), 64'h9ABC_DEF0);

        // mthi during busy must be ignored.
        bus.op_a      = 32'd3;
        bus.op_b      = 32'd4;
        bus.is_signed = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.wdata = 32'hDEAD_BEEF;
        bus.mthi  = 1'b1;
        tick();
        bus.mthi = 1'b0;
        check("mthi_busy_hi", 64'(bus.hi_out), 64'h1234_5678);
        wait_done(cycles);
        check("mthi_busy_res_hi", 64'(bus.hi_out), 64'd0);
        check("mthi_busy_res_lo", 64'(bus.lo_out), 64'd12);
        tick();

        // Both moves in one idle cycle.
        bus.wdata = 32'h0BAD_CAFE;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mt_both_hi", 64'(bus.hi_out), 64'h0BAD_CAFE);
        check("mt_both_lo", 64'(bus.lo_out), 64'h0BAD_CAFE);

        // Move alongside an accepted start: visible, then overwritten.
        bus.op_a      = 32'd5;
        bus.op_b      = 32'd5;
        bus.is_signed = 1'b0;
        bus.wdata     = 32'hCAFE_F00D;
        bus.mthi      = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        bus.start = 1'b0;
        check("mt_start_hi", 64'(bus.hi_out), 64'hCAFE_F00D);
        wait_done(cycles);
        check("mt_start_res_hi", 64'(bus.hi_out), 64'd0);
        check("mt_start_res_lo", 64'(bus.lo_out), 64'd25);
        tick();

        // Second start while busy is ignored; exactly one done.
        bus.op_a      = 32'd7;
        bus.op_b      = 32'd6;
        bus.is_signed = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        dones     = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) begin
                bus.op_a  = 32'd2;
                bus.op_b  = 32'd2;
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            if (bus.done === 1'b1) dones++;
        end
        check("dbl_start_dones", 64'(dones), 64'd1);
        check("dbl_start_hi", 64'(bus.hi_out), ref_product(32'd7, 32'd6, 1'b0) >> 32);
        check("dbl_start_lo", 64'(bus.lo_out), 64'(ref_product(32'd7, 32'd6, 1'b0) & 64'hFFFF_FFFF));

        // Asynchronous reset mid-run aborts with no done pulse.
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi_out), 64'd0);
        check("abort_lo", 64'(bus.lo_out), 64'd0);
        tick();
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_mul("u_9x9", 32'd9, 32'd9, 1'b0);

        // Randomized operands and signedness.
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            run_mul($sformatf("rnd%0d", i), ra, rb, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
Parametrised successor to the HI/LO register pair. It contains an iterative shift-add multiplier (signed or unsigned) with a start/busy/done handshake, plus the architectural HI and LO registers. HI and LO are written either by multiply completion or by direct MTHI/MTLO writes. The block sits beside the ALU in the datapath; the control unit stalls on busy.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO; product is 2*WIDTH bits.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  single-cycle request to begin a multiply; accepted only in IDLE
is_signed  in  1  sampled with start; 1 = two's-complement (MULT), 0 = unsigned (MULTU)
op_a  in  WIDTH  multiplicand, sampled with start
op_b  in  WIDTH  multiplier, sampled with start
mthi  in  1  write wdata to HI; honoured only in IDLE
mtlo  in  1  write wdata to LO; honoured only in IDLE
wdata  in  WIDTH  data for mthi/mtlo
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; HI/LO already hold the new product in that cycle
hi_out  out  WIDTH  current HI register
lo_out  out  WIDTH  current LO register

Behaviour:
- Reset values (asynchronous): state=IDLE, busy=0, done=0, hi_out=0, lo_out=0, counter=0, internal operand/accumulator registers=0.
- States: IDLE, RUN, FINISH.
- IDLE -> RUN on start. Latch |op_a| and |op_b| (magnitudes when is_signed=1, raw values otherwise). Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]). Clear the 2*WIDTH accumulator. Set counter=0.
- RUN, one multiplier bit per cycle, LSB first:
  - if the current multiplier bit is 1, add the shifted multiplicand to the accumulator;
  - shift the multiplier right and the multiplicand left;
  - after exactly WIDTH RUN cycles (counter==WIDTH-1), go to FINISH.
- FINISH: product = neg ? -acc : acc (2*WIDTH-bit two's complement). Write HI=product[2W-1:W] and LO=product[W-1:0] on this edge. done=1 for exactly one cycle. Return to IDLE.
- Latency: start sampled at edge 0; busy high edges 1..WIDTH+1; done and the updated hi_out/lo_out are visible after edge WIDTH+1. For WIDTH=32 that is 33 cycles.
- busy=1 in RUN and FINISH; busy=0 in IDLE.
- start while busy: ignored; the in-flight operation is unaffected.
- mthi/mtlo while busy: ignored, with no write.
- mthi and mtlo in the same IDLE cycle: both registers take wdata.
- mthi/mtlo in the same cycle as an accepted start: the write takes effect, and the later FINISH writeback overwrites it.
- Magnitude of the most negative operand (e.g. 0x80000000) is 2^(W-1), held unsigned in W bits; the accumulator is 2W bits, so no overflow is possible.
- Reset asserted mid-RUN: the operation aborts, everything returns to reset values, and no done pulse is produced.
- hi_out/lo_out are driven directly from registers; no combinational path from inputs to outputs.

Decomposition:
- Shared package hilo_pkg:
  - state enum {IDLE, RUN, FINISH};
  - localparam default WIDTH=32;
  - function abs_w (conditional two's-complement magnitude).
- One natural sub-module: shift_add_core (operand/accumulator registers, counter, add-shift step). The top level holds the FSM, sign fix-up and the HI/LO registers.

Test Plan:
1. Unsigned 0xFFFFFFFF * 0xFFFFFFFF -> done after 33 cycles, HI=0xFFFFFFFE, LO=0x00000001, busy low the cycle after done.
2. Signed -3 (0xFFFFFFFD) * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Signed 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0x00000000.
3. mthi with wdata=0x12345678, then mtlo with wdata=0x9ABCDEF0, both in IDLE -> hi_out=0x12345678, lo_out=0x9ABCDEF0. Then repeat mthi during busy -> HI unchanged until done.
4. Start 7*6, then pulse start with 2*2 at cycle 5 -> second start ignored, HI=0, LO=42, exactly one done pulse.
5. Start 9*9, assert reset at cycle 10 -> busy=0, done never pulses, HI=LO=0. A fresh start of 9*9 afterwards -> LO=81.
6. Unsigned 0 * 0x7FFFFFFF and unsigned 1 * 0xFFFFFFFF -> HI=0, LO=0 and HI=0, LO=0xFFFFFFFF respectively, each with 33-cycle latency.
